// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: access-size and FSM types plus big-endian lane mapping shared by subword_mem.
package cpu_types_pkg;
  typedef enum logic [1:0] {WORD = 2'b00, HALF = 2'b01, BYTE = 2'b10} memsize_t;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} memstate_t;
  localparam logic [31:0] BYTE_LANE = 32'h0000_00ff;
  localparam logic [31:0] HALF_LANE = 32'h0000_ffff;
  localparam logic [31:0] WORD_LANE = 32'hffff_ffff;
  // Lower byte offsets occupy the more significant bits of the word.
  function automatic logic [4:0] lane_shift(memsize_t size, logic [1:0] off);
    return size == BYTE ? {~off, 3'b000} : size == HALF ? {~off[1], 4'b0000} : 5'd0;
  endfunction
  function automatic logic [31:0] lane_mask(memsize_t size);
    return size == BYTE ? BYTE_LANE : size == HALF ? HALF_LANE : WORD_LANE;
  endfunction
endpackage

// File: rtl/lane_merge.sv
// lane_merge: store-lane merge and load-lane extraction.
// SUBWORD_LOAD_EN enables sized/extended loads; otherwise loads pass the cache word through.
module lane_merge
  import cpu_types_pkg::*;
(
  input  memsize_t    size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] store_i,
  input  logic [31:0] load_i,
  output logic [31:0] merged_o,
  output logic [31:0] extracted_o
);
  logic [4:0]  sh;
  logic [31:0] mask;
  always_comb begin
    sh = lane_shift(size_i, off_i);
    mask = lane_mask(size_i);
    merged_o = (rdata_i & ~(mask << sh)) | ((store_i & mask) << sh);
  end
`ifdef SUBWORD_LOAD_EN
  logic [31:0] lane;
  logic        sign;
  always_comb begin
    lane = (load_i >> sh) & mask;
    sign = ~unsigned_i & (size_i == BYTE ? lane[7] : size_i == HALF ? lane[15] : 1'b0);
    extracted_o = lane | (sign ? ~mask : 32'd0);
  end
`else
  logic unused_uns;
  assign unused_uns = unsigned_i;
  assign extracted_o = load_i;
`endif
endmodule

// File: rtl/subword_mem.sv
// subword_mem: byte/half/word access adapter in front of a word-wide data cache.
// Define SUBWORD_LOAD_EN for sized, extended loads with misalignment checks on loads.
module subword_mem
  import cpu_types_pkg::*;
#(
  parameter bit FULL_WORD_BYPASS = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_ren,
  input  logic        req_wen,
  input  memsize_t    req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_store,
  output logic        resp_ready,
  output logic [31:0] resp_load,
  output logic        misalign,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  input  logic [31:0] dmemload,
  input  logic        dhit
);
  memstate_t   state_q, state_d;
  memsize_t    size_q;
  logic [31:0] addr_q, store_q, rdata_q, load_q, merged, extracted;
  logic        uns_q, wen_q, mis_q, accept, misaligned, mis_req;

  assign accept = state_q == IDLE && (req_wen || req_ren);
  assign misaligned = (req_size == HALF && req_addr[0]) || (req_size == WORD && req_addr[1:0] != 2'b00);
`ifdef SUBWORD_LOAD_EN
  assign mis_req = misaligned;
`else
  assign mis_req = misaligned && req_wen;
`endif

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = mis_req ? DONE : (req_wen && req_size == WORD && FULL_WORD_BYPASS) ? WR : RD;
      RD: if (dhit) state_d = wen_q ? WR : DONE;
      WR: if (dhit) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmemREN = state_q == RD;
    dmemWEN = state_q == WR;
    resp_ready = state_q == DONE;
    misalign = resp_ready && mis_q;
    resp_load = load_q;
    dmemaddr = {addr_q[31:2], 2'b00};
    dmemstore = merged;
  end

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      addr_q <= '0;
      size_q <= WORD;
      uns_q <= 1'b0;
      store_q <= '0;
      wen_q <= 1'b0;
      mis_q <= 1'b0;
      rdata_q <= '0;
      load_q <= '0;
    end else if (accept) begin
      addr_q <= req_addr;
      size_q <= req_size;
      uns_q <= req_unsigned;
      store_q <= req_store;
      wen_q <= req_wen;
      mis_q <= mis_req;
      if (mis_req) load_q <= '0;
    end else if (state_q == RD && dhit) begin
      rdata_q <= dmemload;
      if (!wen_q) load_q <= extracted;
    end

  lane_merge u_lane (
    .size_i(size_q),
    .off_i(addr_q[1:0]),
    .unsigned_i(uns_q),
    .rdata_i(rdata_q),
    .store_i(store_q),
    .load_i(dmemload),
    .merged_o(merged),
    .extracted_o(extracted)
  );
endmodule

// File: tb/tb_subword_mem.sv
// tb_subword_mem: directed vectors against a per-transaction timeline and byte-array model.
module tb_subword_mem;
  import cpu_types_pkg::*;
  logic CLK = 0, nRST = 0, req_ren = 0, req_wen = 0, req_unsigned = 0, dhit = 0;
  memsize_t req_size = WORD;
  logic [31:0] req_addr = 0, req_store = 0, dmemload = 0;
  logic resp_ready, misalign, dmemREN, dmemWEN;
  logic [31:0] resp_load, dmemaddr, dmemstore;
  int errors = 0, checks = 0;
  logic active = 0, skip = 1, exp_mis = 0, exp_is_load = 0;
  int t = 0, done_t = 0, rd_n = 0, wr_n = 0, hit_lat = 1, k = 0, ready_t = 0, pulses = 0, p0 = 0;
  logic [31:0] exp_addr = 0, exp_st = 0, exp_ld = 0, last_store = 0, last_load = 0;

  subword_mem dut (
    .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_store(req_store),
    .resp_ready(resp_ready), .resp_load(resp_load), .misalign(misalign),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dmemload(dmemload), .dhit(dhit)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] model_store(logic [31:0] word, memsize_t size, logic [31:0] addr, logic [31:0] data);
    logic [7:0] b [4];
    int o = int'(addr[1:0]);
    if (size == WORD) return data;
    for (int i = 0; i < 4; i++) b[i] = word[31-8*i -: 8];
    if (size == BYTE) b[o] = data[7:0];
    else begin
      b[o] = data[15:8];
      b[o+1] = data[7:0];
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] word, memsize_t size, logic uns, logic [31:0] addr);
    int o = int'(addr[1:0]);
    logic [7:0] v8;
    logic [15:0] v16;
    if (size == WORD) return word;
    if (size == BYTE) begin
      v8 = word[31-8*o -: 8];
      return uns ? {24'd0, v8} : {{24{v8[7]}}, v8};
    end
    v16 = {word[31-8*o -: 8], word[23-8*o -: 8]};
    return uns ? {16'd0, v16} : {{16{v16[15]}}, v16};
  endfunction

  // Cache responder: dhit rises in the hit_lat-th cycle of each RD/WR state.
  always @(negedge CLK) begin
    if (dhit) k = 0;
    if (dmemREN || dmemWEN) begin
      k = k + 1;
      dhit = k >= hit_lat;
    end else begin
      k = 0;
      dhit = 0;
    end
  end

  always @(negedge CLK) begin
    if (active) begin
      t++;
      check("dmemREN", dmemREN, t <= rd_n);
      check("dmemWEN", dmemWEN, t > rd_n && t <= rd_n + wr_n);
      check("resp_ready", resp_ready, t == done_t);
      check("misalign", misalign, t == done_t && exp_mis);
      if (dmemREN || dmemWEN) check("dmemaddr", dmemaddr, exp_addr);
      if (dmemWEN) begin
        check("dmemstore", dmemstore, exp_st);
        last_store = dmemstore;
      end
      if (resp_ready) begin
        pulses++;
        ready_t = t;
        last_load = resp_load;
      end
      if (t >= done_t) begin
        if (exp_is_load || exp_mis) check("resp_load", resp_load, exp_ld);
        active = 0;
      end
    end else if (!skip) begin
      check("idle_REN", dmemREN, 0);
      check("idle_WEN", dmemWEN, 0);
      check("idle_ready", resp_ready, 0);
      check("idle_misalign", misalign, 0);
      if (resp_ready) pulses++;
    end
  end

  task automatic access(input logic wen, input logic ren, input memsize_t size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] data, input logic [31:0] word, input int lat);
    logic mis;
    @(negedge CLK);
    mis = (size == HALF && addr[0]) || (size == WORD && addr[1:0] != 2'b00);
`ifndef SUBWORD_LOAD_EN
    if (!wen) mis = 0;
`endif
    exp_mis = mis;
    exp_is_load = !wen;
    rd_n = (mis || (wen && size == WORD)) ? 0 : lat;
    wr_n = (mis || !wen) ? 0 : lat;
    done_t = rd_n + wr_n + 1;
    exp_addr = {addr[31:2], 2'b00};
    exp_st = (mis || !wen) ? 32'd0 : model_store(word, size, addr, data);
`ifdef SUBWORD_LOAD_EN
    exp_ld = mis ? 32'd0 : model_load(word, size, uns, addr);
`else
    exp_ld = mis ? 32'd0 : word;
`endif
    hit_lat = lat;
    dmemload = word;
    req_wen = wen; req_ren = ren; req_size = size; req_unsigned = uns;
    req_addr = addr; req_store = data;
    @(posedge CLK);
    #1;
    t = 0;
    active = 1;
    req_wen = 0; req_ren = 0; req_size = BYTE; req_unsigned = ~uns;
    req_addr = $urandom; req_store = $urandom;
    for (int n = 0; n < 64 && active; n++) @(negedge CLK);
    if (active) begin
      errors++;
      checks++;
      $display("FAIL timeout: no completion after 64 cycles at %0t", $time);
      active = 0;
    end
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_ready", resp_ready, 0);
    check("rst_misalign", misalign, 0);
    check("rst_REN", dmemREN, 0);
    check("rst_WEN", dmemWEN, 0);
    check("rst_load", resp_load, 0);
    check("rst_addr", dmemaddr, 0);
    check("rst_store", dmemstore, 0);
    nRST = 1;
    skip = 0;

    p0 = pulses;
    access(1, 0, BYTE, 0, 32'h101, 32'hAB, 32'h11223344, 1);
    check("sb_merge", last_store, 32'h11AB3344);
    check("sb_pulses", pulses - p0, 1);
    check("sb_latency", ready_t, 3);

    access(1, 0, HALF, 0, 32'h102, 32'hBEEF, 32'h0, 2);
    check("sh_merge", last_store, 32'h0000BEEF);

    access(0, 1, BYTE, 0, 32'h100, 32'h0, 32'h80FF0000, 1);
`ifdef SUBWORD_LOAD_EN
    check("lb_load", last_load, 32'hFFFFFF80);
`else
    check("lb_load", last_load, 32'h80FF0000);
`endif
    check("load_latency", ready_t, 2);

    access(0, 1, HALF, 1, 32'h100, 32'h0, 32'h80FF0000, 1);
`ifdef SUBWORD_LOAD_EN
    check("lhu_load", last_load, 32'h000080FF);
`else
    check("lhu_load", last_load, 32'h80FF0000);
`endif

    access(0, 1, WORD, 0, 32'h102, 32'h0, 32'hCAFEF00D, 1);
`ifdef SUBWORD_LOAD_EN
    check("lw_mis_load", last_load, 32'h0);
    check("lw_mis_latency", ready_t, 1);
`else
    check("lw_load", last_load, 32'hCAFEF00D);
`endif

    access(1, 0, WORD, 0, 32'h104, 32'hDEADBEEF, 32'h12345678, 5);
    check("sw_store", last_store, 32'hDEADBEEF);
    check("sw_latency", ready_t, 6);

    access(1, 0, HALF, 0, 32'h103, 32'h1234, 32'h0, 1);
    check("sh_mis_latency", ready_t, 1);
    access(1, 0, WORD, 0, 32'h101, 32'h1234, 32'h0, 1);
    check("sw_mis_latency", ready_t, 1);

    access(1, 0, BYTE, 0, 32'h200, 32'hCD, 32'h11223344, 1);
    check("sb0_merge", last_store, 32'hCD223344);
    access(1, 0, BYTE, 0, 32'h203, 32'hFFCD, 32'h11223344, 3);
    check("sb3_merge", last_store, 32'h112233CD);
    access(1, 0, HALF, 0, 32'h200, 32'h99991234, 32'hAABBCCDD, 1);
    check("sh0_merge", last_store, 32'h1234CCDD);

    access(0, 1, HALF, 0, 32'h202, 32'h0, 32'h12348001, 2);
`ifdef SUBWORD_LOAD_EN
    check("lh2_load", last_load, 32'hFFFF8001);
`else
    check("lh2_load", last_load, 32'h12348001);
`endif
    access(0, 1, BYTE, 1, 32'h203, 32'h0, 32'h000000F0, 1);
    check("lbu3_load", last_load, 32'h000000F0);

    access(1, 1, BYTE, 0, 32'h301, 32'h5A, 32'h0, 1);
    check("wen_wins_store", last_store, 32'h005A0000);
    check("wen_wins_latency", ready_t, 3);

    // Reset while an sb sits in RD waiting for a slow cache.
    @(negedge CLK);
    skip = 1;
    hit_lat = 100;
    dmemload = 32'h11223344;
    req_wen = 1; req_size = BYTE; req_addr = 32'h101; req_store = 32'h77;
    @(posedge CLK);
    #1;
    req_wen = 0;
    @(negedge CLK);
    check("rstmid_pre_REN", dmemREN, 1);
    #2;
    nRST = 0;
    #1;
    check("rstmid_REN", dmemREN, 0);
    check("rstmid_WEN", dmemWEN, 0);
    check("rstmid_ready", resp_ready, 0);
    check("rstmid_addr", dmemaddr, 0);
    check("rstmid_store", dmemstore, 0);
    @(negedge CLK);
    nRST = 1;
    p0 = pulses;
    skip = 0;
    repeat (6) @(negedge CLK);
    check("rstmid_no_pulse", pulses - p0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
